grid_mover: RTL and testbench
=============================

Name: grid_mover

Overview:
- Parametrised, tile-aligned sprite mover for Digger actors (player now, monsters later).
- Converts direction requests into fixed-point position updates once per frame.
- Snaps to the grid before it turns, clamps at the board limits, and honours per-direction wall blocks.
- Owns the life cycle: ALIVE, then DYING with an animation timer, then respawn or GAME_OVER.
- Sits between the keyboard/AI direction source and the sprite drawer / collision unit.

Parameters:
- BOARD_X, 32, board top-left X in pixels
- BOARD_Y, 160, board top-left Y in pixels
- TILE_LOG2, 5, log2 of tile size in pixels (32)
- COLS, 15, board width in tiles
- ROWS, 10, board height in tiles
- START_COL, 6, respawn tile column
- START_ROW, 9, respawn tile row
- FRAC_BITS, 6, fixed-point fraction bits
- SPEED, 64, step per frame in 1/2^FRAC_BITS pixel units (64 = 1 px/frame)
- DEATH_FRAMES, 256, frames spent in DYING
- LIVES, 3, lives at reset

Ports:
- clk  in  1  clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- move_req  in  4  bit0 up, bit1 right, bit2 down, bit3 left
- wall_hit  in  4  per-direction block pulse (same bit order), valid until the next startOfFrame
- kill  in  1  fatal collision pulse
- topLeftX  out  11 signed  sprite X in pixels
- topLeftY  out  11 signed  sprite Y in pixels
- direction  out  2  facing: 00 up, 01 right, 10 down, 11 left
- moving  out  1  a nonzero step was applied at the last startOfFrame
- image  out  3  death animation frame index
- alive  out  1  state == ALIVE
- lives_left  out  2  remaining lives
- game_over  out  1  state == GAME_OVER

Behaviour:
- Reset (async, resetN=0):
  - Position = (BOARD_X + START_COL<<TILE_LOG2, BOARD_Y + START_ROW<<TILE_LOG2); with defaults (224,448).
  - direction=11, moving=0, image=0, alive=1, lives_left=LIVES, game_over=0.
  - State ALIVE; death counter and block flags cleared.
  - Reset mid-operation restores all of the above.
- Position storage and timing:
  - Internal position is fixed-point: pixel << FRAC_BITS.
  - Outputs are the arithmetic right shift by FRAC_BITS.
  - All updates occur on the clk edge where startOfFrame=1; outputs are visible the next cycle.
- Block flags: any clk with wall_hit[d]=1 sets block[d]. All flags clear on startOfFrame after use.
- Request resolution at startOfFrame:
  - Opposing pairs (up+down, left+right) cancel.
  - Remaining priority: up > down > left > right.
  - The chosen direction d is dropped if block[d]=1 or the move would leave the board.
- Alignment rule:
  - off = perpendicular-axis pixel coordinate mod tile.
  - off==0: step SPEED along d, and direction <= d.
  - off != 0: step along the perpendicular axis toward the nearest grid line (+ if off >= tile/2, else −); direction unchanged.
  - A snap step that would cross the grid line lands exactly on it (no overshoot).
- Clamp:
  - X limited to [BOARD_X, BOARD_X + (COLS−1)<<TILE_LOG2].
  - Y limited to [BOARD_Y, BOARD_Y + (ROWS−1)<<TILE_LOG2].
  - A step reaching a limit lands exactly on it.
- moving = 1 iff the position changed at that startOfFrame.
- FSM:
  - ALIVE:
    - kill=1 → DYING.
    - Same cycle: lives_left−1 (saturating at 0), counter=0, moving=0.
    - Position freezes.
  - DYING:
    - counter +1 per startOfFrame.
    - image = counter[7:6] scaled to DEATH_FRAMES (top two bits of the counter).
    - kill is ignored.
    - When counter == DEATH_FRAMES−1 at startOfFrame: lives_left>0 → respawn position, direction=11, ALIVE; else → GAME_OVER.
  - GAME_OVER:
    - Frozen; only reset exits.
    - image holds 3'd4 (game-over glyph).
- Simultaneous events:
  - kill and startOfFrame in the same cycle: kill wins; no step is applied.
  - wall_hit and startOfFrame in the same cycle: the block applies to that frame.

Optional Feature:
- Macro: GRID_MOVER_TURN_BUFFER_EN.
- With the macro defined:
  - A perpendicular request made while off != 0 is latched in a one-entry turn buffer.
  - The buffer is executed on the first frame that reaches alignment, even if the key has been released.
  - The buffer expires after 8 frames or on an opposing request.
- Without the macro: requests act only in frames where the key is held.

Decomposition:
- Package grid_mover_pkg holds:
  - dir_t enum (UP=0, RIGHT=1, DOWN=2, LEFT=3)
  - state_t enum (ALIVE, DYING, GAME_OVER)
  - TILE, TILE_MASK and FIXED_ONE constants
- Sub-module grid_axis_step, instanced once for X and once for Y:
  - Inputs: current fixed-point coordinate, signed step, lower/upper limit, snap-target enable.
  - Output: next coordinate with snap and clamp applied.
- FSM, request arbitration and turn buffer stay in grid_mover.

Test Plan:
- Reset defaults → (224,448), direction=11, alive=1, lives_left=3, game_over=0.
- Hold move_req=0010 for 3 frames at Y=448 → X 225,226,227; direction=01; moving=1.
- At X=227, hold move_req=0001 → X 226,225,224 (snap), then Y 447; direction=00 only from the Y step.
- Pulse wall_hit[1] mid-frame with right held → X unchanged that frame, moving=0; the next frame moves again.
- At X=32 hold left → X stays 32 and moving=0. Simultaneous right+left → no motion.
- Pulse kill → alive=0, lives_left=2; image goes 0,1,2,3 every 64 frames; after 256 frames position=(224,448) and alive=1. Three deaths → game_over=1 and image=4 until resetN.

Source files
------------

// File: rtl/grid_mover_pkg.sv
// grid_mover_pkg: shared types, default geometry and small helpers for the grid mover.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package grid_mover_pkg;

    // Facing / request direction; the values match the move_req and wall_hit bit order.
    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        DYING     = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    // Default geometry: 32-pixel tiles, 6 fraction bits (one pixel = 64 units).
    localparam int TILE      = 32;
    localparam int TILE_MASK = TILE - 1;
    localparam int FIXED_ONE = 64;

    // Pixel coordinate width on the sprite outputs.
    localparam int PIX_W = 11;

    // Up/down move along Y, so their alignment is checked on X.
    function automatic logic dir_vert(input dir_t d);
        return (d == UP) || (d == DOWN);
    endfunction

    // Opposite direction: the encoding puts opposites two apart.
    function automatic dir_t dir_opp(input dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

endpackage

// File: rtl/grid_mover_if.sv
// grid_mover_if: frame/request inputs and sprite state outputs of the grid mover.
// Ports: startOfFrame, move_req, wall_hit, kill (towards the mover);
//        topLeftX/Y, direction, moving, image, alive, lives_left, game_over (from the mover).
// Modports: master = direction source / drawer side, slave = the mover itself.
interface grid_mover_if;
    import grid_mover_pkg::*;

    logic                    startOfFrame;
    logic [3:0]              move_req;
    logic [3:0]              wall_hit;
    logic                    kill;
    logic signed [PIX_W-1:0] topLeftX;
    logic signed [PIX_W-1:0] topLeftY;
    logic [1:0]              direction;
    logic                    moving;
    logic [2:0]              image;
    logic                    alive;
    logic [1:0]              lives_left;
    logic                    game_over;

    modport master (
        output startOfFrame, move_req, wall_hit, kill,
        input  topLeftX, topLeftY, direction, moving, image, alive, lives_left, game_over
    );

    modport slave (
        input  startOfFrame, move_req, wall_hit, kill,
        output topLeftX, topLeftY, direction, moving, image, alive, lives_left, game_over
    );

endinterface

// File: rtl/grid_mover_axis_step.sv
// grid_axis_step: one axis of the position update - add step, stop on the grid line when snapping, clamp to limits.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: cur (fixed-point coordinate), step (signed), lo/hi (fixed-point limits), snap_en, nxt (result).
module grid_axis_step
    import grid_mover_pkg::*;
#(
    parameter int W         = 18,
    parameter int FRAC_BITS = $clog2(FIXED_ONE),
    parameter int TILE_LOG2 = $clog2(TILE_MASK + 1)
) (
    input  logic signed [W-1:0] cur,
    input  logic signed [W-1:0] step,
    input  logic signed [W-1:0] lo,
    input  logic signed [W-1:0] hi,
    input  logic                snap_en,
    output logic signed [W-1:0] nxt
);

    // Bits below SH are the sub-tile part of the fixed-point coordinate.
    localparam int SH = FRAC_BITS + TILE_LOG2;
    localparam logic signed [W-1:0] TILE_FX = W'(1 << SH);

    logic signed [W-1:0] line_dn;
    logic signed [W-1:0] line_up;
    logic signed [W-1:0] sum;
    logic                step_pos;
    logic                step_neg;

    always_comb begin
        line_dn  = {cur[W-1:SH], {SH{1'b0}}};
        line_up  = line_dn + TILE_FX;
        step_neg = step[W-1];
        step_pos = !step[W-1] && (step != '0);
        sum      = cur + step;
        // A snap only happens while off the grid, so cur sits strictly between
        // line_dn and line_up; never run past the line being snapped to.
        if (snap_en) begin
            if (step_pos && (sum > line_up)) begin
                sum = line_up;
            end else if (step_neg && (sum < line_dn)) begin
                sum = line_dn;
            end
        end
        if (sum < lo) begin
            nxt = lo;
        end else if (sum > hi) begin
            nxt = hi;
        end else begin
            nxt = sum;
        end
    end

endmodule

// File: rtl/grid_mover.sv
// grid_mover: tile-aligned sprite mover with death/respawn life cycle for one Digger actor.
// Latency: state updates on the startOfFrame edge (kill on any edge), visible the next cycle.
// Backpressure: none; requests not usable in a frame are dropped (optional turn buffer: GRID_MOVER_TURN_BUFFER_EN).
// Ports: clk, resetN (async active-low), bus (grid_mover_if.slave: frame/requests in, sprite state out).
module grid_mover
    import grid_mover_pkg::*;
#(
    parameter int BOARD_X      = 32,
    parameter int BOARD_Y      = 160,
    parameter int TILE_LOG2    = $clog2(TILE),
    parameter int COLS         = 15,
    parameter int ROWS         = 10,
    parameter int START_COL    = 6,
    parameter int START_ROW    = 9,
    parameter int FRAC_BITS    = $clog2(FIXED_ONE),
    parameter int SPEED        = FIXED_ONE,
    parameter int DEATH_FRAMES = 256,
    parameter int LIVES        = 3
) (
    input  logic         clk,
    input  logic         resetN,
    grid_mover_if.slave  bus
);

    // One spare bit above the pixel range keeps clamp compares free of wrap.
    localparam int W  = PIX_W + FRAC_BITS + 1;
    localparam int CW = $clog2(DEATH_FRAMES);

    localparam logic signed [W-1:0] X_MIN_FX   = W'(BOARD_X << FRAC_BITS);
    localparam logic signed [W-1:0] X_MAX_FX   = W'((BOARD_X + ((COLS - 1) << TILE_LOG2)) << FRAC_BITS);
    localparam logic signed [W-1:0] Y_MIN_FX   = W'(BOARD_Y << FRAC_BITS);
    localparam logic signed [W-1:0] Y_MAX_FX   = W'((BOARD_Y + ((ROWS - 1) << TILE_LOG2)) << FRAC_BITS);
    localparam logic signed [W-1:0] X_START_FX = W'((BOARD_X + (START_COL << TILE_LOG2)) << FRAC_BITS);
    localparam logic signed [W-1:0] Y_START_FX = W'((BOARD_Y + (START_ROW << TILE_LOG2)) << FRAC_BITS);
    localparam logic signed [W-1:0] STEP_P     = W'(SPEED);
    localparam logic signed [W-1:0] STEP_N     = -STEP_P;

    state_t              state;
    state_t              state_nxt;
    dir_t                dir_q;
    logic [CW-1:0]       cnt;
    logic [1:0]          lives;
    logic                moving_q;
    logic [3:0]          block;
    logic [3:0]          blk_now;
    logic [3:0]          req_c;
    logic signed [W-1:0] pos_x;
    logic signed [W-1:0] pos_y;
    logic signed [W-1:0] nxt_x;
    logic signed [W-1:0] nxt_y;
    logic signed [W-1:0] step_x;
    logic signed [W-1:0] step_y;
    logic                snap_x;
    logic                snap_y;
    logic                cand_vld;
    dir_t                cand_dir;
    logic                sel_vld;
    dir_t                sel_dir;
    logic                at_limit;
    logic                go;
    logic                turn;
    logic                off_nz;
    logic                off_hi;
    logic [TILE_LOG2-1:0] off_x;
    logic [TILE_LOG2-1:0] off_y;
    logic                offx_nz;
    logic                offy_nz;
    logic                do_step;
    logic                do_die;
    logic                do_respawn;
    logic                cnt_inc;

`ifdef GRID_MOVER_TURN_BUFFER_EN
    logic                tb_vld;
    dir_t                tb_dir;
    logic [2:0]          tb_age;
    logic                tb_use;
`endif

    // Pixel offset inside the tile on each axis.
    assign off_x   = pos_x[FRAC_BITS +: TILE_LOG2];
    assign off_y   = pos_y[FRAC_BITS +: TILE_LOG2];
    assign offx_nz = (off_x != '0);
    assign offy_nz = (off_y != '0);

    // A wall pulse arriving with startOfFrame still blocks that frame.
    assign blk_now = block | bus.wall_hit;

    // Request arbitration and step selection.
    always_comb begin
        req_c = bus.move_req;
        if (req_c[0] && req_c[2]) begin
            req_c[0] = 1'b0;
            req_c[2] = 1'b0;
        end
        if (req_c[1] && req_c[3]) begin
            req_c[1] = 1'b0;
            req_c[3] = 1'b0;
        end

        cand_vld = 1'b1;
        cand_dir = UP;
        if (req_c[0]) begin
            cand_dir = UP;
        end else if (req_c[2]) begin
            cand_dir = DOWN;
        end else if (req_c[3]) begin
            cand_dir = LEFT;
        end else if (req_c[1]) begin
            cand_dir = RIGHT;
        end else begin
            cand_vld = 1'b0;
        end

        sel_vld = cand_vld;
        sel_dir = cand_dir;
`ifdef GRID_MOVER_TURN_BUFFER_EN
        // A buffered turn takes over as soon as its cross axis lines up.
        tb_use = 1'b0;
        if (tb_vld && !(dir_vert(tb_dir) ? offx_nz : offy_nz)) begin
            sel_vld = 1'b1;
            sel_dir = tb_dir;
            tb_use  = 1'b1;
        end
`endif

        off_nz = dir_vert(sel_dir) ? offx_nz : offy_nz;
        off_hi = dir_vert(sel_dir) ? off_x[TILE_LOG2-1] : off_y[TILE_LOG2-1];

        case (sel_dir)
            UP:      at_limit = (pos_y <= Y_MIN_FX);
            DOWN:    at_limit = (pos_y >= Y_MAX_FX);
            LEFT:    at_limit = (pos_x <= X_MIN_FX);
            RIGHT:   at_limit = (pos_x >= X_MAX_FX);
            default: at_limit = 1'b1;
        endcase

        go   = sel_vld && !blk_now[sel_dir] && !at_limit;
        turn = go && !off_nz;

        step_x = '0;
        step_y = '0;
        snap_x = 1'b0;
        snap_y = 1'b0;
        if (go) begin
            if (off_nz) begin
                // Off the grid: slide along the cross axis to the nearest line first.
                if (dir_vert(sel_dir)) begin
                    step_x = off_hi ? STEP_P : STEP_N;
                    snap_x = 1'b1;
                end else begin
                    step_y = off_hi ? STEP_P : STEP_N;
                    snap_y = 1'b1;
                end
            end else begin
                case (sel_dir)
                    UP:      step_y = STEP_N;
                    DOWN:    step_y = STEP_P;
                    LEFT:    step_x = STEP_N;
                    default: step_x = STEP_P;
                endcase
            end
        end
    end

    grid_axis_step #(
        .W         (W),
        .FRAC_BITS (FRAC_BITS),
        .TILE_LOG2 (TILE_LOG2)
    ) u_step_x (
        .cur     (pos_x),
        .step    (step_x),
        .lo      (X_MIN_FX),
        .hi      (X_MAX_FX),
        .snap_en (snap_x),
        .nxt     (nxt_x)
    );

    grid_axis_step #(
        .W         (W),
        .FRAC_BITS (FRAC_BITS),
        .TILE_LOG2 (TILE_LOG2)
    ) u_step_y (
        .cur     (pos_y),
        .step    (step_y),
        .lo      (Y_MIN_FX),
        .hi      (Y_MAX_FX),
        .snap_en (snap_y),
        .nxt     (nxt_y)
    );

    // Life-cycle FSM: state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= ALIVE;
        end else begin
            state <= state_nxt;
        end
    end

    // Life-cycle FSM: next state and datapath strobes. kill beats a same-cycle frame step.
    always_comb begin
        state_nxt  = state;
        do_step    = 1'b0;
        do_die     = 1'b0;
        do_respawn = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            ALIVE: begin
                if (bus.kill) begin
                    state_nxt = DYING;
                    do_die    = 1'b1;
                end else if (bus.startOfFrame) begin
                    do_step = 1'b1;
                end
            end
            DYING: begin
                if (bus.startOfFrame) begin
                    if (cnt == CW'(DEATH_FRAMES - 1)) begin
                        if (lives != 2'd0) begin
                            state_nxt  = ALIVE;
                            do_respawn = 1'b1;
                        end else begin
                            state_nxt = GAME_OVER;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            GAME_OVER: begin
                state_nxt = GAME_OVER;
            end
            default: begin
                state_nxt = ALIVE;
            end
        endcase
    end

    // Position, facing, lives and death timer.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pos_x    <= X_START_FX;
            pos_y    <= Y_START_FX;
            dir_q    <= LEFT;
            moving_q <= 1'b0;
            lives    <= 2'(LIVES);
            cnt      <= '0;
            block    <= '0;
        end else begin
            block <= bus.startOfFrame ? 4'b0000 : (block | bus.wall_hit);
            if (do_die) begin
                lives    <= (lives != 2'd0) ? (lives - 2'd1) : 2'd0;
                cnt      <= '0;
                moving_q <= 1'b0;
            end
            if (do_step) begin
                pos_x    <= nxt_x;
                pos_y    <= nxt_y;
                moving_q <= (nxt_x != pos_x) || (nxt_y != pos_y);
                if (turn) begin
                    dir_q <= sel_dir;
                end
            end
            if (cnt_inc) begin
                cnt <= cnt + CW'(1);
            end
            if (do_respawn) begin
                pos_x    <= X_START_FX;
                pos_y    <= Y_START_FX;
                dir_q    <= LEFT;
                moving_q <= 1'b0;
            end
        end
    end

`ifdef GRID_MOVER_TURN_BUFFER_EN
    // One-entry turn buffer: remembers a turn asked for while off the grid.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tb_vld <= 1'b0;
            tb_dir <= LEFT;
            tb_age <= '0;
        end else if ((state != ALIVE) || bus.kill) begin
            tb_vld <= 1'b0;
        end else if (bus.startOfFrame) begin
            if (tb_use && go) begin
                tb_vld <= 1'b0;
            end else if (tb_vld && cand_vld && (cand_dir == dir_opp(tb_dir))) begin
                tb_vld <= 1'b0;
            end else if (cand_vld && (dir_vert(cand_dir) ? offx_nz : offy_nz)) begin
                tb_vld <= 1'b1;
                tb_dir <= cand_dir;
                tb_age <= '0;
            end else if (tb_vld) begin
                if (tb_age == 3'd7) begin
                    tb_vld <= 1'b0;
                end else begin
                    tb_age <= tb_age + 3'd1;
                end
            end
        end
    end
`endif

    assign bus.topLeftX   = pos_x[FRAC_BITS +: PIX_W];
    assign bus.topLeftY   = pos_y[FRAC_BITS +: PIX_W];
    assign bus.direction  = dir_q;
    assign bus.moving     = moving_q;
    assign bus.alive      = (state == ALIVE);
    assign bus.game_over  = (state == GAME_OVER);
    assign bus.lives_left = lives;

    // Death animation uses the top two timer bits; 4 is the game-over glyph.
    always_comb begin
        case (state)
            DYING:     bus.image = {1'b0, cnt[CW-1 -: 2]};
            GAME_OVER: bus.image = 3'd4;
            default:   bus.image = 3'd0;
        endcase
    end

endmodule

// File: tb/tb_grid_mover.sv
// tb_grid_mover: directed self-checking bench for grid_mover with default parameters.
// Latency: frames are one startOfFrame cycle plus one idle cycle; outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_grid_mover;

    logic clk    = 1'b0;
    logic resetN = 1'b0;

    always #5 clk = ~clk;

    grid_mover_if gif();

    grid_mover dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (gif)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    // One frame: startOfFrame for one cycle with the given inputs, then return at the next falling edge.
    task automatic frame(input logic [3:0] req, input logic [3:0] wh, input logic k);
        @(negedge clk);
        gif.move_req     = req;
        gif.wall_hit     = wh;
        gif.kill         = k;
        gif.startOfFrame = 1'b1;
        @(negedge clk);
        gif.startOfFrame = 1'b0;
        gif.wall_hit     = 4'b0000;
        gif.kill         = 1'b0;
    endtask

    task automatic pulse_kill();
        @(negedge clk);
        gif.kill = 1'b1;
        @(negedge clk);
        gif.kill = 1'b0;
    endtask

    task automatic check_pos(input string tag, input int x, input int y);
        check({tag, "_x"}, gif.topLeftX, x);
        check({tag, "_y"}, gif.topLeftY, y);
    endtask

    // Runs the 256 dying frames (right held, a stray kill on frame 150) and checks the outcome.
    task automatic die_wait(input logic respawn, input int fx, input int fy);
        for (int f = 1; f <= 256; f++) begin
            frame(4'b0010, 4'b0000, f == 150);
            if (f == 63)  check("img_f63", gif.image, 0);
            if (f == 64)  check("img_f64", gif.image, 1);
            if (f == 128) check("img_f128", gif.image, 2);
            if (f == 192) check("img_f192", gif.image, 3);
            if (f == 200) check_pos("dying_frozen", fx, fy);
            if (f == 255) check("alive_f255", gif.alive, 0);
        end
        if (respawn) begin
            check("respawn_alive", gif.alive, 1);
            check_pos("respawn", 224, 448);
            check("respawn_dir", gif.direction, 3);
            check("respawn_img", gif.image, 0);
            check("respawn_go", gif.game_over, 0);
        end else begin
            check("go_flag", gif.game_over, 1);
            check("go_alive", gif.alive, 0);
            check("go_img", gif.image, 4);
        end
    endtask

    initial begin
        gif.startOfFrame = 1'b0;
        gif.move_req     = 4'b0000;
        gif.wall_hit     = 4'b0000;
        gif.kill         = 1'b0;
        resetN           = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        check_pos("rst", 224, 448);
        check("rst_dir", gif.direction, 3);
        check("rst_moving", gif.moving, 0);
        check("rst_img", gif.image, 0);
        check("rst_alive", gif.alive, 1);
        check("rst_lives", gif.lives_left, 3);
        check("rst_go", gif.game_over, 0);
        resetN = 1'b1;

        // Right for three frames on an aligned row.
        for (int i = 1; i <= 3; i++) begin
            frame(4'b0010, 4'b0000, 1'b0);
            check_pos("right", 224 + i, 448);
            check("right_dir", gif.direction, 1);
            check("right_moving", gif.moving, 1);
        end

        // Up while off the column: snap X back to 224 first, then turn.
        for (int i = 1; i <= 3; i++) begin
            frame(4'b0001, 4'b0000, 1'b0);
            check_pos("snap", 227 - i, 448);
            check("snap_dir", gif.direction, 1);
        end
        frame(4'b0001, 4'b0000, 1'b0);
        check_pos("up", 224, 447);
        check("up_dir", gif.direction, 0);

        // Mid-frame wall pulse blocks right for one frame.
        @(negedge clk);
        gif.wall_hit = 4'b0010;
        @(negedge clk);
        gif.wall_hit = 4'b0000;
        frame(4'b0010, 4'b0000, 1'b0);
        check_pos("wall", 224, 447);
        check("wall_moving", gif.moving, 0);
        // Next frame moves again: Y at 447 snaps down onto 448, facing unchanged.
        frame(4'b0010, 4'b0000, 1'b0);
        check_pos("wall_next", 224, 448);
        check("wall_next_moving", gif.moving, 1);
        check("wall_next_dir", gif.direction, 0);
        frame(4'b0010, 4'b0000, 1'b0);
        check_pos("right2", 225, 448);
        check("right2_dir", gif.direction, 1);
        // Wall pulse in the same cycle as startOfFrame.
        frame(4'b0010, 4'b0010, 1'b0);
        check_pos("wall_sof", 225, 448);
        check("wall_sof_moving", gif.moving, 0);

        // Left to the board edge.
        repeat (193) frame(4'b1000, 4'b0000, 1'b0);
        check_pos("left_edge", 32, 448);
        check("left_edge_moving", gif.moving, 1);
        check("left_dir", gif.direction, 3);
        frame(4'b1000, 4'b0000, 1'b0);
        check_pos("left_clamp", 32, 448);
        check("left_clamp_moving", gif.moving, 0);
        // Right+left cancel.
        frame(4'b1010, 4'b0000, 1'b0);
        check_pos("cancel_lr", 32, 448);
        check("cancel_lr_moving", gif.moving, 0);
        // Up+down cancel, right remains.
        frame(4'b0111, 4'b0000, 1'b0);
        check_pos("cancel_ud", 33, 448);
        check("cancel_ud_dir", gif.direction, 1);
        // Down on the bottom row is dropped.
        frame(4'b0100, 4'b0000, 1'b0);
        check_pos("bottom", 33, 448);
        check("bottom_moving", gif.moving, 0);
        check("bottom_dir", gif.direction, 1);

        // First death: standalone kill pulse.
        pulse_kill();
        check("kill1_alive", gif.alive, 0);
        check("kill1_lives", gif.lives_left, 2);
        check("kill1_moving", gif.moving, 0);
        check("kill1_img", gif.image, 0);
        die_wait(1'b1, 33, 448);
        check("life1_lives", gif.lives_left, 2);

        // Second death: kill with startOfFrame and right held, so no step.
        frame(4'b0010, 4'b0000, 1'b1);
        check_pos("kill2", 224, 448);
        check("kill2_alive", gif.alive, 0);
        check("kill2_lives", gif.lives_left, 1);
        die_wait(1'b1, 224, 448);
        check("life2_lives", gif.lives_left, 1);

        // Third death ends the game.
        pulse_kill();
        check("kill3_lives", gif.lives_left, 0);
        die_wait(1'b0, 224, 448);
        frame(4'b1000, 4'b0000, 1'b1);
        frame(4'b1000, 4'b0000, 1'b0);
        check("go_hold", gif.game_over, 1);
        check("go_hold_img", gif.image, 4);
        check_pos("go_frozen", 224, 448);

        // Reset out of GAME_OVER.
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        check("rst2_go", gif.game_over, 0);
        check("rst2_lives", gif.lives_left, 3);
        check("rst2_alive", gif.alive, 1);
        check("rst2_img", gif.image, 0);
        resetN = 1'b1;
        frame(4'b1000, 4'b0000, 1'b0);
        check_pos("rst2_move", 223, 448);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
